// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the RAM arbiter: data width and the requester IDs
// recorded in the "last owner" register.
package ram_arbiter_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_VID  = 2'd1,
    REQ_CPU  = 2'd2
  } req_id_e;

endpackage : ram_arbiter_pkg

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter between the video fetch unit and the CPU.
// Video has priority; a saturating wait counter forces a CPU grant after
// CpuMaxWait consecutive refusals. Read data returns one cycle after the grant.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int Bits       = 16,
  parameter int CpuMaxWait = 4
) (
  input  logic              clk,
  input  logic              reset,
  // video fetch port
  input  logic              vidReq,
  input  logic [Bits-1:0]   vidAddress,
  output logic              vidGnt,
  output logic [DATA_W-1:0] vidData,
  output logic              vidValid,
  // CPU port
  input  logic              cpuReq,
  input  logic              cpuWriteEnabled,
  input  logic [Bits-1:0]   cpuAddress,
  input  logic [DATA_W-1:0] cpuDataIn,
  output logic              cpuGnt,
  output logic [DATA_W-1:0] cpuDataOut,
  output logic              cpuValid,
  // RAM port
  output logic              ramWriteEnabled,
  output logic [Bits-1:0]   ramAddress,
  output logic [DATA_W-1:0] ramDataIn,
  input  logic [DATA_W-1:0] ramDataOut
);

  localparam logic [7:0] MAX_WAIT = 8'(CpuMaxWait);

  logic [7:0]        wait_cnt_q,      wait_cnt_d;
  req_id_e           last_owner_q,    last_owner_d;
  logic              last_was_read_q, last_was_read_d;
  logic [DATA_W-1:0] vid_data_q,      vid_data_d;
  logic [DATA_W-1:0] cpu_data_q,      cpu_data_d;
  logic              cpu_forced;
  logic              cpu_read_gnt;

  // Grant decision: starved CPU first, then video, then CPU; nothing during reset.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    vidGnt     = 1'b0;
    cpuGnt     = 1'b0;
    cpu_forced = cpuReq && (wait_cnt_q == MAX_WAIT);
    if (!reset) begin
      if (cpu_forced)  cpuGnt = 1'b1;
      else if (vidReq) vidGnt = 1'b1;
      else if (cpuReq) cpuGnt = 1'b1;
    end
  end

  // RAM mux: the granted side owns the address; only a granted CPU write may write.
  always_comb begin
    ramAddress      = vidGnt ? vidAddress : cpuAddress;
    ramWriteEnabled = cpuGnt && cpuWriteEnabled;
    ramDataIn       = cpuDataIn;
  end

  // Next-state logic for the wait counter, owner tracking and read-data registers.
  always_comb begin
    cpu_read_gnt = cpuGnt && !cpuWriteEnabled;

    wait_cnt_d = 8'd0;
    if (cpuReq && !cpuGnt) begin
      wait_cnt_d = (wait_cnt_q == MAX_WAIT) ? MAX_WAIT : wait_cnt_q + 8'd1;
    end

    if (vidGnt)      last_owner_d = REQ_VID;
    else if (cpuGnt) last_owner_d = REQ_CPU;
    else             last_owner_d = REQ_NONE;
    last_was_read_d = vidGnt || cpu_read_gnt;

    vid_data_d = vidGnt       ? ramDataOut : vid_data_q;
    cpu_data_d = cpu_read_gnt ? ramDataOut : cpu_data_q;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      wait_cnt_q      <= 8'd0;
      last_owner_q    <= REQ_NONE;
      last_was_read_q <= 1'b0;
      vid_data_q      <= '0;
      cpu_data_q      <= '0;
    end else begin
      wait_cnt_q      <= wait_cnt_d;
      last_owner_q    <= last_owner_d;
      last_was_read_q <= last_was_read_d;
      vid_data_q      <= vid_data_d;
      cpu_data_q      <= cpu_data_d;
    end
  end

  // Valid pulses decode straight from registered state, so they are glitch-free.
  always_comb begin
    vidValid   = (last_owner_q == REQ_VID) && last_was_read_q;
    cpuValid   = (last_owner_q == REQ_CPU) && last_was_read_q;
    vidData    = vid_data_q;
    cpuDataOut = cpu_data_q;
  end

endmodule : ram_arbiter

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a simple RAM, a per-cycle reference model of the
// arbitration rules, and directed scenarios with literal expected values.
module tb_ram_arbiter;

  localparam int BITS     = 16;
  localparam int MAX_WAIT = 4;

  logic            clk;
  logic            reset;
  logic            vidReq;
  logic [15:0]     vidAddress;
  logic            vidGnt;
  logic [7:0]      vidData;
  logic            vidValid;
  logic            cpuReq;
  logic            cpuWriteEnabled;
  logic [15:0]     cpuAddress;
  logic [7:0]      cpuDataIn;
  logic            cpuGnt;
  logic [7:0]      cpuDataOut;
  logic            cpuValid;
  logic            ramWriteEnabled;
  logic [15:0]     ramAddress;
  logic [7:0]      ramDataIn;
  logic [7:0]      ramDataOut;

  int errors = 0;
  int checks = 0;

  ram_arbiter #(.Bits(BITS), .CpuMaxWait(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .vidReq(vidReq), .vidAddress(vidAddress), .vidGnt(vidGnt),
    .vidData(vidData), .vidValid(vidValid),
    .cpuReq(cpuReq), .cpuWriteEnabled(cpuWriteEnabled), .cpuAddress(cpuAddress),
    .cpuDataIn(cpuDataIn), .cpuGnt(cpuGnt), .cpuDataOut(cpuDataOut), .cpuValid(cpuValid),
    .ramWriteEnabled(ramWriteEnabled), .ramAddress(ramAddress),
    .ramDataIn(ramDataIn), .ramDataOut(ramDataOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- RAM: combinational read, write on posedge ----------------
  logic [7:0]  ram_mem [0:65535] = '{default: 8'h00};
  logic        pre_en = 1'b0;
  logic [15:0] pre_addr = '0;
  logic [7:0]  pre_data = '0;

  assign ramDataOut = ram_mem[ramAddress];

  always @(posedge clk) begin
    if (ramWriteEnabled) ram_mem[ramAddress] <= ramDataIn;
    else if (pre_en)     ram_mem[pre_addr]   <= pre_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- Reference model ----------------
  logic [7:0] model_mem [logic [15:0]];
  int         m_refused   = 0;   // consecutive cycles a pending CPU request was refused
  logic       m_vid_valid = 1'b0;
  logic       m_cpu_valid = 1'b0;
  logic [7:0] m_vid_data  = 8'h00;
  logic [7:0] m_cpu_data  = 8'h00;
  logic       armed       = 1'b0;

  function automatic logic [7:0] model_read(input logic [15:0] a);
    return model_mem.exists(a) ? model_mem[a] : 8'h00;
  endfunction

  // Inputs are stable between negedge and the next posedge: check, then advance the model.
  always @(negedge clk) begin
    if (armed) begin
      logic       e_cpu, e_vid, e_we;
      logic [15:0] e_addr;
      logic [7:0]  rd;
      e_cpu  = !reset && cpuReq && (m_refused >= MAX_WAIT || !vidReq);
      e_vid  = !reset && vidReq && !e_cpu;
      e_addr = e_vid ? vidAddress : cpuAddress;
      e_we   = e_cpu && cpuWriteEnabled;

      check("mdl vidGnt",     vidGnt,          e_vid);
      check("mdl cpuGnt",     cpuGnt,          e_cpu);
      check("mdl ramWE",      ramWriteEnabled, e_we);
      check("mdl ramAddress", ramAddress,      e_addr);
      check("mdl ramDataIn",  ramDataIn,       cpuDataIn);
      check("mdl vidValid",   vidValid,        m_vid_valid);
      check("mdl cpuValid",   cpuValid,        m_cpu_valid);
      check("mdl vidData",    vidData,         m_vid_data);
      check("mdl cpuDataOut", cpuDataOut,      m_cpu_data);

      if (reset) begin
        m_refused   = 0;
        m_vid_valid = 1'b0;
        m_cpu_valid = 1'b0;
        m_vid_data  = 8'h00;
        m_cpu_data  = 8'h00;
      end else begin
        rd          = model_read(e_addr);
        m_vid_valid = e_vid;
        m_cpu_valid = e_cpu && !cpuWriteEnabled;
        if (e_vid)       m_vid_data = rd;
        if (m_cpu_valid) m_cpu_data = rd;
        if (e_we)        model_mem[e_addr] = cpuDataIn;
        m_refused = (cpuReq && !e_cpu) ? ((m_refused < MAX_WAIT) ? m_refused + 1 : MAX_WAIT) : 0;
      end
    end
  end

  // ---------------- Stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    pre_en   = 1'b1;
    pre_addr = a;
    pre_data = d;
    model_mem[a] = d;
    step();
    pre_en = 1'b0;
  endtask

  // Video held high, CPU read raised; returns the cycle index of the CPU grant.
  task automatic contention(output int cpu_at);
    vidReq = 1'b1; vidAddress = 16'h2000;
    cpuReq = 1'b1; cpuWriteEnabled = 1'b0; cpuAddress = 16'h0040;
    cpu_at = -1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (cpuGnt === 1'b1) begin
        cpu_at = c;
        step();
        cpuReq = 1'b0;
        break;
      end
      check("contention vidGnt", vidGnt, 1'b1);
      step();
    end
    #1;
    check("contention vidGnt after cpu", vidGnt, 1'b1);
    vidReq = 1'b0;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] exp_burst [4];
    int cpu_at;
    exp_burst = '{8'h08, 8'h80, 8'h08, 8'h80};

    // 1: reset held 3 cycles with both requests high
    reset = 1'b1;
    vidReq = 1'b1; vidAddress = 16'h1234;
    cpuReq = 1'b1; cpuWriteEnabled = 1'b1; cpuAddress = 16'h0040; cpuDataIn = 8'hFF;
    @(posedge clk);
    armed = 1'b1;
    step();
    step();
    check("reset vidGnt",   vidGnt,          1'b0);
    check("reset cpuGnt",   cpuGnt,          1'b0);
    check("reset ramWE",    ramWriteEnabled, 1'b0);
    check("reset vidValid", vidValid,        1'b0);
    check("reset cpuValid", cpuValid,        1'b0);
    check("reset vidData",  vidData,         8'h00);
    check("reset cpuData",  cpuDataOut,      8'h00);
    reset = 1'b0; vidReq = 1'b0; cpuReq = 1'b0; cpuWriteEnabled = 1'b0;
    step();

    // 2: CPU write then read of the same address
    cpuReq = 1'b1; cpuWriteEnabled = 1'b1; cpuAddress = 16'h0040; cpuDataIn = 8'hA5;
    #1;
    check("cpu wr gnt", cpuGnt, 1'b1);
    check("cpu wr we",  ramWriteEnabled, 1'b1);
    step();
    cpuWriteEnabled = 1'b0;
    #1;
    check("cpu rd gnt",        cpuGnt,   1'b1);
    check("cpu wr no valid",   cpuValid, 1'b0);
    step();
    cpuReq = 1'b0;
    #1;
    check("cpu rd valid", cpuValid,   1'b1);
    check("cpu rd data",  cpuDataOut, 8'hA5);
    step();
    check("cpu valid pulse", cpuValid, 1'b0);

    // 3: video burst
    for (int i = 0; i < 4; i++) preload(16'(16'h2000 + i), exp_burst[i]);
    vidReq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vidAddress = 16'(16'h2000 + i);
      #1;
      check("burst gnt", vidGnt, 1'b1);
      if (i > 0) begin
        check("burst valid", vidValid, 1'b1);
        check("burst data",  vidData,  exp_burst[i-1]);
      end
      step();
    end
    vidReq = 1'b0;
    #1;
    check("burst last valid", vidValid, 1'b1);
    check("burst last data",  vidData,  8'h80);
    step();
    check("burst valid end", vidValid, 1'b0);

    // 4: contention with video held high
    contention(cpu_at);
    check("contention cpu grant cycle", cpu_at, 4);

    // 5: simultaneous single requests
    step();
    vidReq = 1'b1; vidAddress = 16'h2001;
    cpuReq = 1'b1; cpuWriteEnabled = 1'b0; cpuAddress = 16'h0040;
    #1;
    check("simul vid wins", vidGnt, 1'b1);
    check("simul cpu waits", cpuGnt, 1'b0);
    step();
    vidReq = 1'b0;
    #1;
    check("simul cpu next", cpuGnt,  1'b1);
    check("simul vid data", vidData, 8'h80);
    step();
    cpuReq = 1'b0;
    #1;
    check("simul cpu data", cpuDataOut, 8'hA5);
    step();

    // 6: build up CPU wait, then reset during a CPU write request
    vidReq = 1'b1; vidAddress = 16'h2002;
    cpuReq = 1'b1; cpuWriteEnabled = 1'b0;
    step();
    step();
    vidReq = 1'b0;
    cpuWriteEnabled = 1'b1; cpuAddress = 16'h0040; cpuDataIn = 8'h11;
    reset = 1'b1;
    #1;
    check("rst-wr cpuGnt", cpuGnt,          1'b0);
    check("rst-wr ramWE",  ramWriteEnabled, 1'b0);
    step();
    reset = 1'b0; cpuReq = 1'b0;
    #1;
    check("rst-wr cpuValid", cpuValid,   1'b0);
    check("rst-wr vidValid", vidValid,   1'b0);
    check("rst-wr cpuData",  cpuDataOut, 8'h00);
    cpuReq = 1'b1; cpuWriteEnabled = 1'b0;
    #1;
    check("rst-wr read gnt", cpuGnt, 1'b1);
    step();
    cpuReq = 1'b0;
    #1;
    check("rst-wr old value", cpuDataOut, 8'hA5);
    step();
    contention(cpu_at);
    check("wait cleared by reset", cpu_at, 4);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_ram_arbiter
